// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
//   Shared definitions for the sequential shift-add multiplier:
//   - state_t   : FSM state encoding (IDLE / CALC / DONE)
//   - cnt_width : width of the step counter, wide enough to hold N
// -----------------------------------------------------------------------------
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter is loaded with N, so it needs clog2(N+1) bits.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// -----------------------------------------------------------------------------
// mul_sign_fix
//   Combinational conditional two's-complement negate, W bits wide.
//   Used as |v| (neg = sign bit of v) on the operands and as the final
//   sign restore on the 2W-bit product.
//
//   Ports:
//     a    in  W  value to transform
//     neg  in  1  1 = output -a, 0 = output a
//     y    out W  result (wraps modulo 2^W, so |-2^(W-1)| = 2^(W-1) unsigned)
// -----------------------------------------------------------------------------
module mul_sign_fix #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    always_comb begin
        y = neg ? (-a) : a;
    end

endmodule

// File: rtl/seq_mul.sv
// -----------------------------------------------------------------------------
// seq_mul
//   Sequential radix-2 shift-add multiplier with signed/unsigned mode and a
//   start/busy/done handshake. One N+1-bit adder, N compute cycles, one
//   result every N+1 cycles when start is held high.
//
//   Ports:
//     clk        in  1   rising-edge clock
//     rst_n      in  1   asynchronous active-low reset
//     start      in  1   request a multiply (accepted in IDLE or DONE)
//     is_signed  in  1   1 = two's-complement operands, sampled with start
//     x          in  N   multiplicand, sampled with start
//     y          in  N   multiplier, sampled with start
//     busy       out 1   high while computing
//     done       out 1   one-cycle pulse, p holds a new result
//     p          out 2N  product, held until the next result completes
// -----------------------------------------------------------------------------
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = cnt_width(N);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     a_mag;
    logic             neg;
    // Upper half: running partial sum. Lower half: the multiplier magnitude,
    // consumed LSB-first as the whole register shifts right; after N steps
    // the full 2N-bit unsigned product sits in acc.
    logic [2*N-1:0]   acc;

    logic [N-1:0]     x_abs;
    logic [N-1:0]     y_abs;
    logic [N:0]       sum;
    logic [2*N-1:0]   acc_next;
    logic [2*N-1:0]   p_fix;

    // Operand magnitudes at capture (raw when unsigned).
    mul_sign_fix #(.W(N)) u_fix_x (
        .a   (x),
        .neg (is_signed & x[N-1]),
        .y   (x_abs)
    );

    mul_sign_fix #(.W(N)) u_fix_y (
        .a   (y),
        .neg (is_signed & y[N-1]),
        .y   (y_abs)
    );

    // One shift-add step: N+1-bit sum keeps the carry, then shift right.
    always_comb begin
        sum      = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? a_mag : {N{1'b0}})};
        acc_next = {sum, acc[N-1:1]};
    end

    // Sign restore on the final step's accumulator; a zero product stays zero.
    mul_sign_fix #(.W(2*N)) u_fix_p (
        .a   (acc_next),
        .neg (neg),
        .y   (p_fix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_mag <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_mag <= x_abs;
                        neg   <= is_signed & (x[N-1] ^ y[N-1]);
                        acc   <= {{N{1'b0}}, y_abs};
                        cnt   <= CW'(N);
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    // Last step: publish the signed result on this same edge.
                    if (cnt == CW'(1)) begin
                        p     <= p_fix;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
module tb_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start8, sgn8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] p8;

    logic        start4, sgn4, busy4, done4;
    logic [3:0]  x4, y4;
    logic [7:0]  p4;

    logic        start16, sgn16, busy16, done16;
    logic [15:0] x16, y16;
    logic [31:0] p16;

    int n_cmp = 0;
    int n_bad = 0;

    seq_mul #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
        .x(x8), .y(y8), .busy(busy8), .done(done8), .p(p8)
    );

    seq_mul #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(sgn4),
        .x(x4), .y(y4), .busy(busy4), .done(done4), .p(p4)
    );

    seq_mul #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16),
        .x(x16), .y(y16), .busy(busy16), .done(done16), .p(p16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // N=8 op: returns negedges from the accept edge until done is seen,
    // scrambles operands after acceptance to prove they were captured.
    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic busy_after);
        @(negedge clk);
        sgn8 = s; x8 = a; y8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; x8 = ~a; y8 = ~b; sgn8 = ~s;
        busy_after = busy8;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b);
        int t;
        int ia, ib, pr;
        logic [31:0] pv;
        @(negedge clk);
        sgn4 = s; x4 = a; y4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        t = 0;
        while (!done4 && t < 20) begin
            @(negedge clk);
            t++;
        end
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        pr = ia * ib;
        pv = pr;
        check("n4_done", done4, 1);
        check("n4_busy", busy4, 0);
        check("n4_prod", p4, pv[7:0]);
    endtask

    task automatic run16(input logic s, input logic [15:0] a, input logic [15:0] b);
        int t;
        longint ia, ib, pr;
        logic [63:0] pv;
        @(negedge clk);
        sgn16 = s; x16 = a; y16 = b; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        t = 0;
        while (!done16 && t < 40) begin
            @(negedge clk);
            t++;
        end
        ia = s ? longint'($signed(a)) : longint'(a);
        ib = s ? longint'($signed(b)) : longint'(b);
        pr = ia * ib;
        pv = pr;
        check("n16_done", done16 & ~busy16, 1);
        check("n16_prod", p16, pv[31:0]);
    endtask

    initial begin
        int lat;
        int cnt;
        logic bz;

        rst_n = 1'b0;
        start8 = 0; sgn8 = 0; x8 = 0; y8 = 0;
        start4 = 0; sgn4 = 0; x4 = 0; y4 = 0;
        start16 = 0; sgn16 = 0; x16 = 0; y16 = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_p", p8, 16'h0000);
        rst_n = 1'b1;

        // Unsigned 255*255, latency and hold.
        run8(1'b0, 8'hFF, 8'hFF, lat, bz);
        check("u_busy_after_accept", bz, 1);
        check("u_latency", lat, 8);
        check("u_busy_at_done", busy8, 0);
        check("u_ff_ff", p8, 16'hFE01);
        @(negedge clk);
        check("u_done_pulse_width", done8, 0);
        repeat (3) @(negedge clk);
        check("u_p_held", p8, 16'hFE01);

        // Signed corners.
        run8(1'b1, 8'h80, 8'h80, lat, bz);
        check("s_80_80", p8, 16'h4000);
        run8(1'b1, 8'h80, 8'h7F, lat, bz);
        check("s_80_7f", p8, 16'hC080);
        run8(1'b1, 8'hFF, 8'h01, lat, bz);
        check("s_ff_01", p8, 16'hFFFF);

        // Same bits, both modes.
        run8(1'b0, 8'hFF, 8'h02, lat, bz);
        check("u_ff_02", p8, 16'h01FE);
        run8(1'b1, 8'hFF, 8'h02, lat, bz);
        check("s_ff_02", p8, 16'hFFFE);

        // Zero operand: full latency, no negative zero.
        run8(1'b1, 8'h00, 8'h85, lat, bz);
        check("s_zero_latency", lat, 8);
        check("s_zero", p8, 16'h0000);

        // start held high: one result every 9 cycles.
        @(negedge clk);
        sgn8 = 1'b0; x8 = 8'd3; y8 = 8'd5; start8 = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done8 && cnt < 40);
        check("hold_first_done", done8, 1);
        check("hold_first_p", p8, 16'd15);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done8 && cnt < 40);
        check("hold_interval", cnt, 9);
        check("hold_second_p", p8, 16'd15);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_idle_busy", busy8, 0);

        // start pulsed mid-CALC is ignored.
        @(negedge clk);
        sgn8 = 1'b0; x8 = 8'd7; y8 = 8'd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; x8 = 8'd100; y8 = 8'd100;
        lat = 0;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        start8 = 1'b1;
        @(negedge clk);
        lat++;
        start8 = 1'b0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("ign_latency", lat, 8);
        check("ign_p", p8, 16'd63);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) cnt++;
        end
        check("ign_no_extra_done", cnt, 0);
        check("ign_p_held", p8, 16'd63);

        // Reset on cycle 4 of CALC.
        @(negedge clk);
        sgn8 = 1'b0; x8 = 8'hFF; y8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        check("mid_rst_p", p8, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) cnt++;
        end
        check("post_rst_quiet", cnt, 0);
        check("post_rst_p", p8, 16'h0000);

        // N=4 exhaustive, both modes.
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run4(m[0], a[3:0], b[3:0]);
                end
            end
        end

        // N=16 corners plus a random sweep.
        run16(1'b1, 16'h8000, 16'h8000);
        run16(1'b0, 16'hFFFF, 16'hFFFF);
        run16(1'b1, 16'h8000, 16'h7FFF);
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            run16(i[0], ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
